// File: rtl/iram_pkg.sv
// Shared constants and owner encoding for the IRAM arbiter.
package iram_pkg;

  localparam int IRAM_ADDR_W = 12;
  localparam int BURST_W     = 4;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2
  } owner_e;

endpackage

// File: rtl/iram_arb_pick.sv
// Combinational winner selection between fetch and loader for the shared IRAM.
module iram_arb_pick (
  input  logic if_req,
  input  logic ld_req,
  input  logic burst_max,
  output logic if_win,
  output logic ld_win
);

  // Loader has priority, except when it has used up its burst allowance while fetch waits.
  always_comb begin
    ld_win = ld_req && !(if_req && burst_max);
    if_win = if_req && !ld_win;
  end

endmodule

// File: rtl/iram_arbiter.sv
// Arbitrates the single-port IRAM between instruction fetch and the program loader.
// Define IRAM_ARB_ERR_EN to add if_err/ld_err and block misaligned/out-of-range accesses.
//
// owner_q   | meaning
// OWN_NONE  | no access issued last cycle, no rvalid due
// OWN_FETCH | fetch access issued last cycle, if_rvalid due now
// OWN_LOAD  | loader access issued last cycle, ld_rvalid due now
module iram_arbiter
  import iram_pkg::*;
#(
  parameter int ADDR_W    = IRAM_ADDR_W,
  parameter int MAX_BURST = 4
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [3:0]        ld_be,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [31:0]       ld_rdata,
`ifdef IRAM_ARB_ERR_EN
  output logic              if_err,
  output logic              ld_err,
`endif
  output logic              ram_cs,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  logic               if_win;
  logic               ld_win;
  logic               burst_max;
  logic [BURST_W-1:0] burst_cnt;
  owner_e             owner_q;
  owner_e             owner_d;
  logic               if_bad;
  logic               ld_bad;
  logic               err_d;
  logic               rd_zero;

  assign burst_max = (burst_cnt == BURST_W'(MAX_BURST));

  iram_arb_pick u_pick (
    .if_req    (if_req && !rst),
    .ld_req    (ld_req && !rst),
    .burst_max (burst_max),
    .if_win    (if_win),
    .ld_win    (ld_win)
  );

  assign if_gnt = if_win;
  assign ld_gnt = ld_win;

`ifdef IRAM_ARB_ERR_EN
  logic err_q;

  assign if_bad  = (if_addr[1:0] != 2'b00) || (if_addr[31:ADDR_W+2] != '0);
  assign ld_bad  = (ld_addr[1:0] != 2'b00) || (ld_addr[31:ADDR_W+2] != '0);
  assign rd_zero = rst || err_q;
  assign if_err  = !rst && err_q && (owner_q == OWN_FETCH);
  assign ld_err  = !rst && err_q && (owner_q == OWN_LOAD);

  always_ff @(posedge sclk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`else
  // Byte-offset and upper address bits are intentionally dropped in this build.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], if_addr[31:ADDR_W+2],
                              ld_addr[1:0], ld_addr[31:ADDR_W+2]};
  assign if_bad  = 1'b0;
  assign ld_bad  = 1'b0;
  assign rd_zero = rst;
`endif

  always_comb begin
    ram_cs    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = if_addr[ADDR_W+1:2];
    ram_wdata = '0;
    owner_d   = OWN_NONE;
    err_d     = 1'b0;
    if (rst) begin
      ram_addr = '0;
    end else if (ld_gnt) begin
      ram_cs    = !ld_bad;
      ram_we    = (ld_we && !ld_bad) ? ld_be : 4'b0000;
      ram_addr  = ld_addr[ADDR_W+1:2];
      ram_wdata = ld_wdata;
      owner_d   = OWN_LOAD;
      err_d     = ld_bad;
    end else if (if_gnt) begin
      ram_cs  = !if_bad;
      owner_d = OWN_FETCH;
      err_d   = if_bad;
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      owner_q   <= OWN_NONE;
      burst_cnt <= '0;
    end else begin
      owner_q <= owner_d;
      if (if_gnt || !if_req)
        burst_cnt <= '0;
      else if (ld_gnt && (burst_cnt < BURST_W'(MAX_BURST)))
        burst_cnt <= burst_cnt + BURST_W'(1);
    end
  end

  assign if_rvalid = !rst && (owner_q == OWN_FETCH);
  assign ld_rvalid = !rst && (owner_q == OWN_LOAD);
  assign if_rdata  = rd_zero ? 32'h0 : ram_rdata;
  assign ld_rdata  = rd_zero ? 32'h0 : ram_rdata;

endmodule

// File: tb/tb_iram_arbiter.sv
// Self-checking bench for iram_arbiter with a behavioural 4096x32 RAM and rdata scoreboards.
module tb_iram_arbiter;
  import iram_pkg::*;

  localparam int ADDR_W    = 12;
  localparam int MAX_BURST = 4;

  logic              sclk;
  logic              rst;
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              ld_req;
  logic              ld_we;
  logic [3:0]        ld_be;
  logic [31:0]       ld_addr;
  logic [31:0]       ld_wdata;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [31:0]       ld_rdata;
`ifdef IRAM_ARB_ERR_EN
  logic              if_err;
  logic              ld_err;
`endif
  logic              ram_cs;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic [31:0] exp_if [$];
  logic [31:0] exp_ld [$];
  bit          exp_ld_wr [$];

  iram_arbiter #(.ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
    .sclk      (sclk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ld_req    (ld_req),
    .ld_we     (ld_we),
    .ld_be     (ld_be),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_gnt    (ld_gnt),
    .ld_rvalid (ld_rvalid),
    .ld_rdata  (ld_rdata),
`ifdef IRAM_ARB_ERR_EN
    .if_err    (if_err),
    .ld_err    (ld_err),
`endif
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  // RAM model: 1-cycle read latency, byte-granular writes
  always @(posedge sclk) begin
    if (ram_cs) begin
      if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
      else
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req   = 1'b0;
    ld_req   = 1'b0;
    ld_we    = 1'b0;
    ld_be    = 4'b0000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h0000_0010;
    ld_req = 1'b1; ld_we = 1'b1; ld_be = 4'hF; ld_addr = 32'h0000_0020; ld_wdata = 32'h5A5A_5A5A;
    @(negedge sclk);
    tests++;
    if (if_gnt !== 1'b0 || ld_gnt !== 1'b0 || ram_cs !== 1'b0 || ram_we !== 4'b0) begin
      fails++;
      $display("FAIL reset_ctrl: if_gnt=%b ld_gnt=%b ram_cs=%b ram_we=%b, want all 0", if_gnt, ld_gnt, ram_cs, ram_we);
    end
    tests++;
    if (ram_addr !== '0 || ram_wdata !== 32'h0 || if_rvalid !== 1'b0 || ld_rvalid !== 1'b0 ||
        if_rdata !== 32'h0 || ld_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: ram_addr=%h ram_wdata=%h if_rvalid=%b ld_rvalid=%b if_rdata=%h ld_rdata=%h, want all 0",
               ram_addr, ram_wdata, if_rvalid, ld_rvalid, if_rdata, ld_rdata);
    end
    step();
    idle_inputs();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_fetch_only();
    idle_inputs();
    if_req = 1'b1; if_addr = 32'h0000_0010;
    @(negedge sclk);
    tests++;
    if (if_gnt !== 1'b1 || ld_gnt !== 1'b0 || ram_cs !== 1'b1 || ram_we !== 4'b0 || ram_addr !== 12'd4) begin
      fails++;
      $display("FAIL fetch_grant: if_gnt=%b ld_gnt=%b cs=%b we=%b addr=%0d, want 1 0 1 0000 4",
               if_gnt, ld_gnt, ram_cs, ram_we, ram_addr);
    end
    exp_if.push_back(32'hDEAD_BEEF);
    step();
    idle_inputs();
    @(negedge sclk);
    tests++;
    if (if_rvalid !== 1'b1 || ld_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL fetch_rvalid: if_rvalid=%b ld_rvalid=%b, want 1 0", if_rvalid, ld_rvalid);
    end
    tests++;
    if (exp_if.size() == 0) begin
      fails++;
      $display("FAIL fetch_data: scoreboard empty, got %h", if_rdata);
    end else if (if_rdata !== exp_if[0]) begin
      fails++;
      $display("FAIL fetch_data: got %h want %h", if_rdata, exp_if[0]);
      void'(exp_if.pop_front());
    end else void'(exp_if.pop_front());
    step();
`ifndef IRAM_ARB_ERR_EN
    // upper and byte-offset bits are dropped: 0xFFFF_0011 maps to word 4
    if_req = 1'b1; if_addr = 32'hFFFF_0011;
    @(negedge sclk);
    tests++;
    if (if_gnt !== 1'b1 || ram_cs !== 1'b1 || ram_addr !== 12'd4) begin
      fails++;
      $display("FAIL fetch_trunc: if_gnt=%b cs=%b addr=%0d, want 1 1 4", if_gnt, ram_cs, ram_addr);
    end
    step();
    idle_inputs();
    @(negedge sclk);
    tests++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL fetch_trunc_data: rvalid=%b data=%h, want 1 deadbeef", if_rvalid, if_rdata);
    end
    step();
`endif
  endtask

  task automatic test_loader_write();
    idle_inputs();
    ld_req = 1'b1; ld_we = 1'b1; ld_be = 4'b0011; ld_addr = 32'h0000_0020; ld_wdata = 32'h1234_5678;
    @(negedge sclk);
    tests++;
    if (ld_gnt !== 1'b1 || if_gnt !== 1'b0 || ram_cs !== 1'b1 || ram_we !== 4'b0011 ||
        ram_addr !== 12'd8 || ram_wdata !== 32'h1234_5678) begin
      fails++;
      $display("FAIL ld_write: gnt=%b cs=%b we=%b addr=%0d wdata=%h, want 1 1 0011 8 12345678",
               ld_gnt, ram_cs, ram_we, ram_addr, ram_wdata);
    end
    exp_ld.push_back(32'h0); exp_ld_wr.push_back(1'b1);
    step();
    // zero byte-enable write: selects the RAM, writes nothing, still acknowledged
    ld_be = 4'b0000; ld_wdata = 32'hFFFF_FFFF;
    @(negedge sclk);
    tests++;
    if (ld_rvalid !== 1'b1 || exp_ld.size() == 0) begin
      fails++;
      $display("FAIL ld_write_ack: ld_rvalid=%b pending=%0d, want 1 and pending", ld_rvalid, exp_ld.size());
    end else begin
      void'(exp_ld.pop_front()); void'(exp_ld_wr.pop_front());
    end
    tests++;
    if (ld_gnt !== 1'b1 || ram_cs !== 1'b1 || ram_we !== 4'b0000) begin
      fails++;
      $display("FAIL ld_be_zero: gnt=%b cs=%b we=%b, want 1 1 0000", ld_gnt, ram_cs, ram_we);
    end
    exp_ld.push_back(32'h0); exp_ld_wr.push_back(1'b1);
    step();
    idle_inputs();
    if_req = 1'b1; if_addr = 32'h0000_0020;
    @(negedge sclk);
    tests++;
    if (ld_rvalid !== 1'b1 || if_rvalid !== 1'b0 || exp_ld.size() == 0) begin
      fails++;
      $display("FAIL ld_be_zero_ack: ld_rvalid=%b if_rvalid=%b, want 1 0", ld_rvalid, if_rvalid);
    end else begin
      void'(exp_ld.pop_front()); void'(exp_ld_wr.pop_front());
    end
    exp_if.push_back(32'hAAAA_5678);
    ref_mem[8] = 32'hAAAA_5678;
    step();
    idle_inputs();
    @(negedge sclk);
    tests++;
    if (if_rvalid !== 1'b1 || exp_if.size() == 0) begin
      fails++;
      $display("FAIL rmw_rvalid: if_rvalid=%b, want 1", if_rvalid);
    end else if (if_rdata !== exp_if[0]) begin
      fails++;
      $display("FAIL rmw_data: got %h want %h", if_rdata, exp_if[0]);
      void'(exp_if.pop_front());
    end else void'(exp_if.pop_front());
    step();
  endtask

  task automatic test_burst();
    bit exp_f, prev_f;
    int wait_cnt, max_wait;
    wait_cnt = 0; max_wait = 0; prev_f = 1'b0;
    idle_inputs();
    if_req = 1'b1; if_addr = 32'h0000_0044;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h0000_0040;
    for (int i = 0; i < 12; i++) begin
      exp_f = (i % 5 == 4);
      @(negedge sclk);
      if (i > 0) begin
        tests++;
        if (if_rvalid !== prev_f || ld_rvalid !== !prev_f) begin
          fails++;
          $display("FAIL burst_rvalid[%0d]: if_rvalid=%b ld_rvalid=%b, want %b %b", i, if_rvalid, ld_rvalid, prev_f, !prev_f);
        end
        if (prev_f && exp_if.size() != 0) begin
          tests++;
          if (if_rdata !== exp_if[0]) begin
            fails++;
            $display("FAIL burst_if_data[%0d]: got %h want %h", i, if_rdata, exp_if[0]);
          end
          void'(exp_if.pop_front());
        end else if (!prev_f && exp_ld.size() != 0) begin
          tests++;
          if (ld_rdata !== exp_ld[0]) begin
            fails++;
            $display("FAIL burst_ld_data[%0d]: got %h want %h", i, ld_rdata, exp_ld[0]);
          end
          void'(exp_ld.pop_front()); void'(exp_ld_wr.pop_front());
        end
      end
      tests++;
      if (if_gnt !== exp_f || ld_gnt !== !exp_f || ram_cs !== 1'b1) begin
        fails++;
        $display("FAIL burst_grant[%0d]: if_gnt=%b ld_gnt=%b cs=%b, want %b %b 1", i, if_gnt, ld_gnt, ram_cs, exp_f, !exp_f);
      end
      if (if_gnt === 1'b1) wait_cnt = 0;
      else begin
        wait_cnt++;
        if (wait_cnt > max_wait) max_wait = wait_cnt;
      end
      if (exp_f) exp_if.push_back(ref_mem[17]);
      else begin exp_ld.push_back(ref_mem[16]); exp_ld_wr.push_back(1'b0); end
      prev_f = exp_f;
      step();
    end
    idle_inputs();
    @(negedge sclk);
    tests++;
    if (ld_rvalid !== 1'b1 || exp_ld.size() == 0 || ld_rdata !== exp_ld[0]) begin
      fails++;
      $display("FAIL burst_last: ld_rvalid=%b data=%h", ld_rvalid, ld_rdata);
    end
    if (exp_ld.size() != 0) begin void'(exp_ld.pop_front()); void'(exp_ld_wr.pop_front()); end
    tests++;
    if (max_wait > MAX_BURST) begin
      fails++;
      $display("FAIL burst_wait: fetch waited %0d cycles, limit %0d", max_wait, MAX_BURST);
    end
    step();
  endtask

  task automatic test_alternate();
    bit cur_f, prev_f;
    int word;
    prev_f = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      cur_f = (i % 2 == 0);
      if (cur_f) begin
        word = 20 + i;
        if_req = 1'b1; if_addr = 32'(word) << 2;
      end else begin
        word = 40 + i;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'(word) << 2;
      end
      @(negedge sclk);
      if (i > 0) begin
        tests++;
        if (if_rvalid !== prev_f || ld_rvalid !== !prev_f) begin
          fails++;
          $display("FAIL alt_rvalid[%0d]: if_rvalid=%b ld_rvalid=%b, want %b %b", i, if_rvalid, ld_rvalid, prev_f, !prev_f);
        end
        tests++;
        if (prev_f) begin
          if (exp_if.size() == 0 || if_rdata !== exp_if[0]) begin
            fails++;
            $display("FAIL alt_if_data[%0d]: got %h", i, if_rdata);
          end
          if (exp_if.size() != 0) void'(exp_if.pop_front());
        end else begin
          if (exp_ld.size() == 0 || ld_rdata !== exp_ld[0]) begin
            fails++;
            $display("FAIL alt_ld_data[%0d]: got %h", i, ld_rdata);
          end
          if (exp_ld.size() != 0) begin void'(exp_ld.pop_front()); void'(exp_ld_wr.pop_front()); end
        end
      end
      tests++;
      if (if_gnt !== cur_f || ld_gnt !== !cur_f || ram_cs !== 1'b1 || ram_addr !== 12'(word)) begin
        fails++;
        $display("FAIL alt_grant[%0d]: if_gnt=%b ld_gnt=%b cs=%b addr=%0d, want %b %b 1 %0d",
                 i, if_gnt, ld_gnt, ram_cs, ram_addr, cur_f, !cur_f, word);
      end
      if (cur_f) exp_if.push_back(ref_mem[word]);
      else begin exp_ld.push_back(ref_mem[word]); exp_ld_wr.push_back(1'b0); end
      prev_f = cur_f;
      step();
    end
    idle_inputs();
    @(negedge sclk);
    tests++;
    if (ld_rvalid !== 1'b1 || if_rvalid !== 1'b0 || exp_ld.size() == 0 || ld_rdata !== exp_ld[0]) begin
      fails++;
      $display("FAIL alt_last: ld_rvalid=%b if_rvalid=%b data=%h", ld_rvalid, if_rvalid, ld_rdata);
    end
    if (exp_ld.size() != 0) begin void'(exp_ld.pop_front()); void'(exp_ld_wr.pop_front()); end
    step();
    @(negedge sclk);
    tests++;
    if (if_rvalid !== 1'b0 || ld_rvalid !== 1'b0 || exp_if.size() != 0 || exp_ld.size() != 0) begin
      fails++;
      $display("FAIL alt_drain: if_rvalid=%b ld_rvalid=%b pending if=%0d ld=%0d, want 0 0 0 0",
               if_rvalid, ld_rvalid, exp_if.size(), exp_ld.size());
    end
    step();
  endtask

  task automatic test_reset_mid();
    bit exp_f;
    idle_inputs();
    if_req = 1'b1; if_addr = 32'h0000_0010;
    @(negedge sclk);
    tests++;
    if (if_gnt !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_grant: if_gnt=%b, want 1", if_gnt);
    end
    step();
    rst = 1'b1;
    ld_req = 1'b1; ld_we = 1'b1; ld_be = 4'hF; ld_addr = 32'h0000_0030; ld_wdata = 32'hCAFE_F00D;
    @(negedge sclk);
    tests++;
    if (if_rvalid !== 1'b0 || if_rdata !== 32'h0 || ld_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_rvalid: if_rvalid=%b if_rdata=%h ld_rvalid=%b, want 0 0 0", if_rvalid, if_rdata, ld_rvalid);
    end
    tests++;
    if (if_gnt !== 1'b0 || ld_gnt !== 1'b0 || ram_cs !== 1'b0 || ram_we !== 4'b0 ||
        ram_addr !== '0 || ram_wdata !== 32'h0) begin
      fails++;
      $display("FAIL rstmid_outs: gnt=%b%b cs=%b we=%b addr=%h wdata=%h, want all 0",
               if_gnt, ld_gnt, ram_cs, ram_we, ram_addr, ram_wdata);
    end
    step();
    rst = 1'b0;
    idle_inputs();
    @(negedge sclk);
    tests++;
    if (dut.burst_cnt !== 4'd0 || if_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_release: burst_cnt=%0d if_rvalid=%b, want 0 0", dut.burst_cnt, if_rvalid);
    end
    step();
    // build up burst_cnt, reset, then the full L,L,L,L,F pattern must restart
    if_req = 1'b1; if_addr = 32'h0000_0044;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h0000_0040;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_f = (i == 4);
      @(negedge sclk);
      tests++;
      if (if_gnt !== exp_f || ld_gnt !== !exp_f) begin
        fails++;
        $display("FAIL rst_burst[%0d]: if_gnt=%b ld_gnt=%b, want %b %b", i, if_gnt, ld_gnt, exp_f, !exp_f);
      end
      step();
    end
    idle_inputs();
    step();
  endtask

`ifdef IRAM_ARB_ERR_EN
  task automatic test_err();
    idle_inputs();
    if_req = 1'b1; if_addr = 32'h0000_4000;
    @(negedge sclk);
    tests++;
    if (if_gnt !== 1'b1 || ram_cs !== 1'b0) begin
      fails++;
      $display("FAIL err_fetch_grant: if_gnt=%b cs=%b, want 1 0", if_gnt, ram_cs);
    end
    step();
    idle_inputs();
    ld_req = 1'b1; ld_we = 1'b1; ld_be = 4'hF; ld_addr = 32'h0000_4020; ld_wdata = 32'h0BAD_0BAD;
    @(negedge sclk);
    tests++;
    if (if_rvalid !== 1'b1 || if_err !== 1'b1 || if_rdata !== 32'h0 || ld_err !== 1'b0) begin
      fails++;
      $display("FAIL err_fetch_resp: rvalid=%b err=%b data=%h ld_err=%b, want 1 1 0 0", if_rvalid, if_err, if_rdata, ld_err);
    end
    tests++;
    if (ld_gnt !== 1'b1 || ram_cs !== 1'b0 || ram_we !== 4'b0) begin
      fails++;
      $display("FAIL err_ld_grant: gnt=%b cs=%b we=%b, want 1 0 0000", ld_gnt, ram_cs, ram_we);
    end
    step();
    idle_inputs();
    @(negedge sclk);
    tests++;
    if (ld_rvalid !== 1'b1 || ld_err !== 1'b1 || if_err !== 1'b0) begin
      fails++;
      $display("FAIL err_ld_resp: rvalid=%b err=%b if_err=%b, want 1 1 0", ld_rvalid, ld_err, if_err);
    end
    step();
  endtask
`endif

  initial begin
    for (int k = 0; k < 4096; k++) begin
      mem[k]     = 32'hC0DE_0000 | 32'(k);
      ref_mem[k] = 32'hC0DE_0000 | 32'(k);
    end
    mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
    mem[8] = 32'hAAAA_AAAA; ref_mem[8] = 32'hAAAA_AAAA;
    rst = 1'b1;
    if_addr = 32'h0; ld_addr = 32'h0; ld_wdata = 32'h0;
    idle_inputs();
    step();
    test_reset();
    test_fetch_only();
    test_loader_write();
    test_burst();
    test_alternate();
    test_reset_mid();
`ifdef IRAM_ARB_ERR_EN
    test_err();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
